// File: rtl/lcd_hd44780_nibble_receiver_if.sv
// Driver-side HD44780 4-bit bus (E, RS, RW, DB[7:4]) as seen by the receiver model.
// The driver owns every wire, so the receiver only ever takes the slave modport.
interface lcd_hd44780_nibble_receiver_if;
  logic       lcd_e;
  logic       lcd_rs;
  logic       lcd_rw;
  logic [3:0] lcd_db;

  modport master (output lcd_e, lcd_rs, lcd_rw, lcd_db);
  modport slave  (input  lcd_e, lcd_rs, lcd_rw, lcd_db);
endinterface

// File: rtl/lcd_hd44780_nibble_receiver.sv
// HD44780 receiver model: rebuilds bytes from E strobes, decodes the driver's instruction subset, keeps a 2x16 DDRAM shadow.
// byte_valid 2 cycles after the E fall, shadow/AC update 1 cycle later; no backpressure, strobes while busy are dropped and flagged.
module lcd_hd44780_nibble_receiver #(
  parameter int unsigned MIN_E_HIGH = 12,
  parameter logic [7:0]  CLEAR_CHAR = 8'h20
) (
  input  logic                         qzt_clk,
  input  logic                         reset,
  lcd_hd44780_nibble_receiver_if.slave lcd,
  input  logic [4:0]                   rd_addr,
  output logic [7:0]                   rd_data,
  output logic                         byte_valid,
  output logic                         byte_rs,
  output logic [7:0]                   byte_data,
  output logic [6:0]                   addr_counter,
  output logic                         bus4_mode,
  output logic                         busy,
  output logic [2:0]                   err
);

  localparam int CW = $clog2(MIN_E_HIGH + 1);

  typedef enum logic [1:0] {ST_BUS8, ST_HIGH, ST_LOW} bus_state_e;

  bus_state_e    state_q;
  logic          e_q, rs_q, rw_q;
  logic [3:0]    db_q, hi_q;
  logic [CW-1:0] cnt_e_q;
  logic          pend_q, id_q, busy_q, bus4_q;
  logic [4:0]    fill_idx_q;
  logic          byte_valid_q, byte_rs_q;
  logic [7:0]    byte_data_q, rd_data_q;
  logic [6:0]    ac_q, ac_step_d;
  logic [2:0]    err_q;
  logic [7:0]    shadow_q [32];

  logic e_fall, e_long, in_shadow;

  assign e_fall    = e_q && !lcd.lcd_e;
  assign e_long    = (cnt_e_q == CW'(MIN_E_HIGH));
  assign in_shadow = (ac_q[5:4] == 2'b00);

  // Row ends wrap to the other row's start; anything else is plain modulo-128.
  always_comb begin
    ac_step_d = id_q ? ac_q + 7'd1 : ac_q - 7'd1;
    if (id_q && ac_q == 7'h27)       ac_step_d = 7'h40;
    else if (id_q && ac_q == 7'h67)  ac_step_d = 7'h00;
    else if (!id_q && ac_q == 7'h00) ac_step_d = 7'h67;
    else if (!id_q && ac_q == 7'h40) ac_step_d = 7'h27;
  end

  always_ff @(posedge qzt_clk) begin
    rd_data_q <= shadow_q[rd_addr];
    if (reset) begin
      state_q      <= ST_BUS8;
      e_q          <= 1'b0;
      rs_q         <= 1'b0;
      rw_q         <= 1'b0;
      db_q         <= '0;
      hi_q         <= '0;
      cnt_e_q      <= '0;
      pend_q       <= 1'b0;
      id_q         <= 1'b1;
      busy_q       <= 1'b1;
      bus4_q       <= 1'b0;
      fill_idx_q   <= '0;
      byte_valid_q <= 1'b0;
      byte_rs_q    <= 1'b0;
      byte_data_q  <= '0;
      ac_q         <= '0;
      err_q        <= '0;
    end else begin
      e_q  <= lcd.lcd_e;
      rs_q <= lcd.lcd_rs;
      rw_q <= lcd.lcd_rw;
      db_q <= lcd.lcd_db;
      if (!lcd.lcd_e)   cnt_e_q <= '0;
      else if (!e_long) cnt_e_q <= cnt_e_q + CW'(1);

      pend_q       <= 1'b0;
      byte_valid_q <= pend_q;

      // rs/rw/db registers still hold the last high-E sample on the falling edge.
      if (e_fall) begin
        if (busy_q)       err_q[1] <= 1'b1;
        else if (rw_q)    err_q[2] <= 1'b1;
        else if (!e_long) err_q[0] <= 1'b1;
        else begin
          case (state_q)
            ST_BUS8: begin
              pend_q      <= 1'b1;
              byte_rs_q   <= rs_q;
              byte_data_q <= {db_q, 4'h0};
              if (!rs_q && db_q == 4'h2) begin
                bus4_q  <= 1'b1;
                state_q <= ST_HIGH;
              end
            end
            ST_HIGH: begin
              hi_q    <= db_q;
              state_q <= ST_LOW;
            end
            default: begin
              pend_q      <= 1'b1;
              byte_rs_q   <= rs_q;
              byte_data_q <= {hi_q, db_q};
              state_q     <= ST_HIGH;
            end
          endcase
        end
      end

      if (busy_q) begin
        shadow_q[fill_idx_q] <= CLEAR_CHAR;
        fill_idx_q           <= fill_idx_q + 5'd1;
        if (fill_idx_q == 5'd31) busy_q <= 1'b0;
      end else if (byte_valid_q) begin
        if (byte_rs_q) begin
          if (in_shadow) shadow_q[{ac_q[6], ac_q[3:0]}] <= byte_data_q;
          ac_q <= ac_step_d;
        end else begin
          casez (byte_data_q)
            8'b1???????: ac_q <= byte_data_q[6:0];
            8'b000001??: id_q <= byte_data_q[1];
            8'b0000001?: ac_q <= '0;
            8'b00000001: begin
              ac_q       <= '0;
              id_q       <= 1'b1;
              busy_q     <= 1'b1;
              fill_idx_q <= '0;
            end
            default: ;
          endcase
        end
      end
    end
  end

  assign rd_data      = rd_data_q;
  assign byte_valid   = byte_valid_q;
  assign byte_rs      = byte_rs_q;
  assign byte_data    = byte_data_q;
  assign addr_counter = ac_q;
  assign bus4_mode    = bus4_q;
  assign busy         = busy_q;
  assign err          = err_q;

endmodule

// File: tb/tb_lcd_hd44780_nibble_receiver.sv
// Directed plus randomized bench for the HD44780 receiver model, checked against a byte-level display model.
module tb_lcd_hd44780_nibble_receiver;

  logic       qzt_clk = 1'b0;
  logic       reset;
  logic [4:0] rd_addr;
  logic [7:0] rd_data, byte_data;
  logic       byte_valid, byte_rs, bus4_mode, busy;
  logic [6:0] addr_counter;
  logic [2:0] err;

  lcd_hd44780_nibble_receiver_if bus();

  lcd_hd44780_nibble_receiver dut (
    .qzt_clk      (qzt_clk),
    .reset        (reset),
    .lcd          (bus),
    .rd_addr      (rd_addr),
    .rd_data      (rd_data),
    .byte_valid   (byte_valid),
    .byte_rs      (byte_rs),
    .byte_data    (byte_data),
    .addr_counter (addr_counter),
    .bus4_mode    (bus4_mode),
    .busy         (busy),
    .err          (err)
  );

  always #5 qzt_clk = ~qzt_clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Monitor: counts byte pulses and busy cycles, remembers the last accepted byte.
  int         bv_cnt = 0;
  int         busy_samples = 0;
  logic [8:0] last_bv = '0;
  always @(negedge qzt_clk) begin
    if (byte_valid) begin
      bv_cnt++;
      last_bv = {byte_rs, byte_data};
    end
    if (busy) busy_samples++;
  end

  // Reference display model: 32 cells, address counter as an integer, entry direction.
  logic [7:0] m_shadow [32];
  int         m_ac;
  bit         m_id;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < 32; i++) m_shadow[i] = 8'h20;
    m_ac = 0;
    m_id = 1'b1;
  endtask

  function automatic int next_ac(input int a, input bit inc);
    if (inc) return (a == 39) ? 64 : (a == 103) ? 0 : (a + 1) % 128;
    return (a == 0) ? 103 : (a == 64) ? 39 : (a + 127) % 128;
  endfunction

  task automatic model_byte(input bit rs, input logic [7:0] b);
    if (rs) begin
      if (m_ac < 16)                  m_shadow[m_ac] = b;
      else if (m_ac >= 64 && m_ac < 80) m_shadow[m_ac - 48] = b;
      m_ac = next_ac(m_ac, m_id);
    end else if (b >= 128) m_ac = int'(b) - 128;
    else if (b >= 64) ;
    else if (b >= 4 && b < 8) m_id = b[1];
    else if (b == 2 || b == 3) m_ac = 0;
    else if (b == 1) model_clear();
  endtask

  task automatic strobe(input bit rs, input bit rw, input logic [3:0] nib, input int hi, input int lo);
    bus.lcd_rs = rs;
    bus.lcd_rw = rw;
    bus.lcd_db = nib;
    bus.lcd_e  = 1'b1;
    repeat (hi) @(negedge qzt_clk);
    bus.lcd_e = 1'b0;
    repeat (lo) @(negedge qzt_clk);
    bus.lcd_rw = 1'b0;
  endtask

  task automatic strobe8(input logic [3:0] nib, input bit exp_bus4);
    int pre;
    pre = bv_cnt;
    strobe(1'b0, 1'b0, nib, 20, 4);
    check("bus8_bv_cnt", 32'(bv_cnt - pre), 32'd1);
    check("bus8_bv_dat", 32'(last_bv), 32'({1'b0, nib, 4'h0}));
    check("bus8_bus4", 32'(bus4_mode), 32'(exp_bus4));
    model_byte(1'b0, {nib, 4'h0});
  endtask

  task automatic send_byte(input bit rs, input logic [7:0] b, input int hi);
    int pre;
    pre = bv_cnt;
    strobe(rs, 1'b0, b[7:4], hi, 4);
    strobe(rs, 1'b0, b[3:0], hi, 4);
    model_byte(rs, b);
    check("byte_bv_cnt", 32'(bv_cnt - pre), 32'd1);
    check("byte_bv_dat", 32'(last_bv), 32'({rs, b}));
    check("byte_ac", 32'(addr_counter), 32'(m_ac));
  endtask

  task automatic check_shadow(input string tag);
    for (int i = 0; i < 32; i++) begin
      rd_addr = 5'(i);
      @(negedge qzt_clk);
      check($sformatf("%s_cell%0d", tag, i), 32'(rd_data), 32'(m_shadow[i]));
    end
  endtask

  task automatic wait_idle(input string tag);
    int c;
    c = 0;
    while (busy && c < 200) begin
      @(negedge qzt_clk);
      c++;
    end
    check({tag, "_busy_timeout"}, 32'(busy), 32'd0);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    repeat (3) @(negedge qzt_clk);
    check("rst_bv", 32'(byte_valid), 32'd0);
    check("rst_ac", 32'(addr_counter), 32'd0);
    check("rst_bus4", 32'(bus4_mode), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    check("rst_busy", 32'(busy), 32'd1);
    reset = 1'b0;
    model_clear();
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int pre, pre_busy, c, a;
    logic [7:0] b;
    reset = 1'b1;
    rd_addr = '0;
    bus.lcd_e = 1'b0; bus.lcd_rs = 1'b0; bus.lcd_rw = 1'b0; bus.lcd_db = '0;
    @(negedge qzt_clk);

    // Reset: 32-cycle fill, then every cell holds the clear character.
    do_reset();
    c = 0;
    while (busy && c < 200) begin
      @(negedge qzt_clk);
      c++;
    end
    check("rst_fill_len", 32'(c), 32'd32);
    check_shadow("rst");

    // 8-bit init sequence ending in Function Set DL=0.
    strobe8(4'h3, 1'b0);
    strobe8(4'h3, 1'b0);
    strobe8(4'h3, 1'b0);
    strobe8(4'h2, 1'b1);

    send_byte(1'b0, 8'h80, 20);
    send_byte(1'b1, 8'h4C, 20);
    send_byte(1'b1, 8'h41, 20);
    send_byte(1'b1, 8'h50, 20);
    check("lap_ac", 32'(addr_counter), 32'h03);
    check_shadow("lap");

    // Row-0 end is off-shadow, the next step lands on row 1.
    send_byte(1'b0, 8'hA7, 20);
    send_byte(1'b1, 8'h31, 20);
    send_byte(1'b1, 8'h32, 20);
    check("wrap_ac", 32'(addr_counter), 32'h41);
    check_shadow("wrap");

    for (int i = 0; i < 60; i++) begin
      case ($urandom_range(0, 9))
        0: begin
          case ($urandom_range(0, 4))
            0: a = $urandom_range(0, 15);
            1: a = $urandom_range(64, 79);
            2: a = $urandom_range(32, 39);
            3: a = $urandom_range(96, 103);
            default: a = $urandom_range(0, 127);
          endcase
          send_byte(1'b0, 8'h80 | 8'(a), 20);
        end
        1: send_byte(1'b0, 8'h04 | 8'($urandom_range(0, 3)), 20);
        2: send_byte(1'b0, 8'h02 | 8'($urandom_range(0, 1)), 20);
        3: send_byte(1'b0, 8'h40 | 8'($urandom_range(0, 63)), 20);
        default: send_byte(1'b1, 8'($urandom_range(32, 126)), 20);
      endcase
    end
    check_shadow("rand");

    // Clear Display, then a strobe arriving during the fill.
    pre = bv_cnt;
    pre_busy = busy_samples;
    strobe(1'b0, 1'b0, 4'h0, 20, 4);
    strobe(1'b0, 1'b0, 4'h1, 20, 3);
    strobe(1'b1, 1'b0, 4'h5, 14, 2);
    wait_idle("clr");
    model_byte(1'b0, 8'h01);
    check("clr_bv_cnt", 32'(bv_cnt - pre), 32'd1);
    check("clr_bv_dat", 32'(last_bv), 32'h001);
    check("clr_busy_len", 32'(busy_samples - pre_busy), 32'd32);
    check("clr_err", 32'(err), 32'b010);
    check("clr_ac", 32'(addr_counter), 32'd0);
    check_shadow("clr");

    // Short E pulse is rejected and leaves the nibble phase alone.
    pre = bv_cnt;
    strobe(1'b1, 1'b0, 4'h7, 5, 4);
    check("short_err", 32'(err), 32'b011);
    check("short_bv", 32'(bv_cnt - pre), 32'd0);
    send_byte(1'b1, 8'h5A, 20);

    // One cycle below the minimum is rejected; exactly the minimum is accepted.
    pre = bv_cnt;
    strobe(1'b1, 1'b0, 4'h4, 11, 4);
    check("e11_bv", 32'(bv_cnt - pre), 32'd0);
    send_byte(1'b1, 8'h4B, 12);

    pre = bv_cnt;
    strobe(1'b1, 1'b1, 4'h6, 20, 4);
    check("rw_err", 32'(err), 32'b111);
    check("rw_bv", 32'(bv_cnt - pre), 32'd0);
    send_byte(1'b1, 8'h21, 20);
    check_shadow("err");

    // Reset mid-pair: back to 8-bit mode, errors cleared, fill rerun.
    strobe(1'b1, 1'b0, 4'h5, 20, 4);
    do_reset();
    wait_idle("rst2");
    check("rst2_err", 32'(err), 32'd0);
    strobe8(4'h2, 1'b1);
    b = 8'h51;
    send_byte(1'b1, b, 20);
    check_shadow("rst2");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
